// File: rtl/alu_share_arbiter.sv
// Two-port round-robin arbiter sharing one combinational ALU.
// Single-entry registered result buffer with valid/ready on both sides.
package CorePack;
    typedef logic [63:0] data_t;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        SLL  = 4'd2,
        SLT  = 4'd3,
        SLTU = 4'd4,
        XOR  = 4'd5,
        SRL  = 4'd6,
        SRA  = 4'd7,
        OR   = 4'd8,
        AND  = 4'd9,
        ADDW = 4'd10,
        SUBW = 4'd11,
        SLLW = 4'd12,
        SRLW = 4'd13,
        SRAW = 4'd14
    } alu_op_enum;
endpackage

module alu_share_arbiter
    import CorePack::*;
#(
    parameter int N_REQ = 2,
    parameter int TAG_W = 4
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [N_REQ-1:0]                  req_valid,
    output logic [N_REQ-1:0]                  req_ready,
    input  data_t [N_REQ-1:0]                 req_a,
    input  data_t [N_REQ-1:0]                 req_b,
    input  alu_op_enum [N_REQ-1:0]            req_op,
    input  logic [N_REQ-1:0][TAG_W-1:0]       req_tag,
    output logic [N_REQ-1:0]                  rsp_valid,
    input  logic [N_REQ-1:0]                  rsp_ready,
    output data_t                             rsp_res,
    output logic [TAG_W-1:0]                  rsp_tag,
    output logic                              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e            state_q;
    logic              owner_q;
    logic              rr_ptr_q;
    data_t             res_q;
    logic [TAG_W-1:0]  tag_q;

    logic              acc;
    logic              any_req;
    logic              gnt;
    data_t             alu_res;

    function automatic data_t sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    function automatic data_t alu(input data_t a,
                                  input data_t b,
                                  input alu_op_enum op);
        logic [31:0] w;
        data_t       r;
        w = 32'd0;
        r = 64'd0;
        case (op)
            ADD:  r = a + b;
            SUB:  r = a - b;
            SLL:  r = a << b[5:0];
            SLT:  r = {63'd0, $signed(a) < $signed(b)};
            SLTU: r = {63'd0, a < b};
            XOR:  r = a ^ b;
            SRL:  r = a >> b[5:0];
            SRA:  r = $signed(a) >>> b[5:0];
            OR:   r = a | b;
            AND:  r = a & b;
            ADDW: begin
                w = a[31:0] + b[31:0];
                r = sext32(w);
            end
            SUBW: begin
                w = a[31:0] - b[31:0];
                r = sext32(w);
            end
            SLLW: begin
                w = a[31:0] << b[4:0];
                r = sext32(w);
            end
            SRLW: begin
                w = a[31:0] >> b[4:0];
                r = sext32(w);
            end
            SRAW: begin
                w = $signed(a[31:0]) >>> b[4:0];
                r = sext32(w);
            end
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    // Accept when empty, or when the owner drains in this same cycle.
    always_comb begin
        acc     = (state_q == IDLE) |
                  ((state_q == HOLD) & rsp_ready[owner_q]);
        any_req = |req_valid;
        gnt     = 1'b0;
        case (req_valid)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = rr_ptr_q;
            default: gnt = 1'b0;
        endcase
        req_ready = 2'b00;
        if (acc && any_req) begin
            req_ready = gnt ? 2'b10 : 2'b01;
        end
        alu_res = alu(req_a[gnt], req_b[gnt], req_op[gnt]);
    end

    // Result-buffer FSM: capture on accept, release on owner drain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
            res_q    <= 64'd0;
            tag_q    <= '0;
        end else if (acc && any_req) begin
            state_q  <= HOLD;
            owner_q  <= gnt;
            rr_ptr_q <= ~gnt;
            res_q    <= alu_res;
            tag_q    <= req_tag[gnt];
        end else if (state_q == HOLD && rsp_ready[owner_q]) begin
            state_q  <= IDLE;
        end
    end

    // Response side is a pure decode of the held state.
    always_comb begin
        rsp_valid = 2'b00;
        if (state_q == HOLD) begin
            rsp_valid = owner_q ? 2'b10 : 2'b01;
        end
        rsp_res = res_q;
        rsp_tag = tag_q;
        busy    = (state_q == HOLD);
    end

endmodule
